// File: rtl/sub_digit_serial.sv
// Digit-serial subtractor: D = A - B - BIN, one 2-bit digit per cycle, LSB digit first.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
module sub_digit_serial #(
    parameter int WIDTH = 8
) (
    input  logic             CLKIN,
    input  logic             RESETN,
    input  logic             I_VALID,
    output logic             I_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic [WIDTH-1:0] D,
    output logic             COUT,
    output logic [1:0]       DBG_STATE
);

    localparam int NDIG = WIDTH / 2;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             cout_q, cout_d;
    logic [1:0]       a_dig, b_dig;
    logic [2:0]       s;

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            k_q     <= '0;
            c_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            c_q     <= c_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        c_d     = c_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        cout_d  = cout_q;
        a_dig   = 2'b00;
        b_dig   = 2'b00;

        // Constant-index digit mux keeps selects width-clean for every WIDTH.
        for (int i = 0; i < NDIG; i++) begin
            if (k_q == KW'(i)) begin
                a_dig = a_q[2*i +: 2];
                b_dig = b_q[2*i +: 2];
            end
        end
        // 3 - b is the 2-bit complement of b; carry in is the inverted borrow.
        s = {1'b0, a_dig} + {1'b0, ~b_dig} + {2'b00, c_q};

        case (state_q)
            IDLE: begin
                if (I_VALID) begin
                    a_d     = A;
                    b_d     = B;
                    c_d     = ~BIN;
                    d_d     = '0;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NDIG; i++) begin
                    if (k_q == KW'(i)) begin
                        d_d[2*i +: 2] = s[1:0];
                    end
                end
                c_d = s[2];
                if (k_q == K_LAST) begin
                    cout_d  = s[2];
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + K_ONE;
                end
            end
            DONE: begin
                if (O_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign I_READY   = (state_q == IDLE) && RESETN;
    assign O_VALID   = (state_q == DONE);
    assign D         = d_q;
    assign COUT      = cout_q;
    assign DBG_STATE = state_q;

endmodule
